// File: rtl/reg_dump.sv
// Register-file debug dump engine: halts the CPU pipeline, walks every register
// through a spare async read port and streams (addr, data) beats over valid/ready.
module reg_dump #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  // state | meaning
  // IDLE  | waiting for start; start is only looked at here
  // HALT  | halt_req raised, waiting (no timeout) for halt_ack
  // READ  | capture rd_data for the current index into the output beat
  // SEND  | beat presented, held until out_ready
  // FIN   | done pulse, halt released, back to IDLE
  typedef enum logic [2:0] {IDLE, HALT, READ, SEND, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] index;

  assign rd_addr = index;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      index     <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halt_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT;
            index    <= '0;
            halt_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack) state <= READ;
        end
        READ, SEND: begin
          // Losing the halt wins over capture or handshake; a beat accepted
          // on this same edge has already left, anything pending is dropped.
          if (!halt_ack) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            halt_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            aborted   <= 1'b1;
          end else if (state == READ) begin
            out_data  <= rd_data;
            out_addr  <= index;
            out_valid <= 1'b1;
            state     <= SEND;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (index == LAST_IDX) begin
              state    <= FIN;
              halt_req <= 1'b0;
              done     <= 1'b1;
            end else begin
              index <= index + 1'b1;
              state <= READ;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a small register-file model feeds rd_data and a
// negedge monitor records every accepted beat and every done pulse.
module tb_reg_dump;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clock = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          halt_ack = 1'b0;
  logic          out_ready = 1'b0;
  logic          halt_req, out_valid, busy, done, aborted;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [DW-1:0] mem [NR];

  assign rd_data = mem[rd_addr];

  reg_dump #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .halt_req(halt_req),
    .halt_ack(halt_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int            cyc = 0;
  logic [AW-1:0] b_addr[$];
  logic [DW-1:0] b_data[$];
  int            done_cnt, abort_cnt, stab_err, first_valid_cyc, done_cyc;
  logic          halt_at_done, busy_at_done;
  logic          prev_pend = 1'b0, prev_ack = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  // Inputs change just after posedge, so negedge values are what the DUT samples next.
  always @(negedge clock) begin
    cyc++;
    if (n_rst) begin
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_pend && prev_ack &&
          (!out_valid || out_addr !== prev_addr || out_data !== prev_data)) stab_err++;
      if (out_valid && out_ready) begin
        b_addr.push_back(out_addr);
        b_data.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        halt_at_done = halt_req;
        busy_at_done = busy;
        if (aborted) abort_cnt++;
      end
      prev_pend = out_valid && !out_ready;
      prev_ack  = halt_ack;
      prev_addr = out_addr;
      prev_data = out_data;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic clear_mon();
    b_addr.delete();
    b_data.delete();
    done_cnt = 0; abort_cnt = 0; stab_err = 0;
    first_valid_cyc = -1; done_cyc = -1;
    halt_at_done = 1'bx; busy_at_done = 1'bx;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_beat(input logic [AW-1:0] a, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (out_valid && out_addr == a) begin ok = 1'b1; break; end
    end
  endtask

  // Mismatches between the recorded beats and n in-order beats addr i / data i*1111h.
  function automatic int bad_beats(int n);
    int b;
    b = (b_addr.size() != n) ? 1 : 0;
    for (int i = 0; i < b_addr.size() && i < n; i++)
      if (b_addr[i] !== AW'(i) || b_data[i] !== DW'(i * 'h1111)) b++;
    return b;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    #12;
    checks++; if ({halt_req, out_valid, busy, done, aborted} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {halt_req, out_valid, busy, done, aborted}); end
    checks++; if ({rd_addr, out_addr, out_data} !== '0) begin
      errors++; $display("FAIL reset_bus: got rd=%0d oa=%0d od=%h want 0", rd_addr, out_addr, out_data); end
    tick();
    n_rst = 1'b1;
    repeat (2) tick();
    checks++; if ({halt_req, out_valid, busy, done} !== 4'b0) begin
      errors++; $display("FAIL idle_flags: got %b want 0000", {halt_req, out_valid, busy, done}); end
  endtask

  task automatic test_full_dump();
    bit ok;
    halt_ack = 1'b1; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got no done want done"); end
    #1;
    checks++; if (bad_beats(8) != 0) begin
      errors++; $display("FAIL full_beats: got %0d bad/%0d beats want 0/8", bad_beats(8), b_addr.size()); end
    checks++; if (halt_at_done !== 1'b0 || busy_at_done !== 1'b1) begin
      errors++; $display("FAIL full_done_cycle: got halt=%b busy=%b want halt=0 busy=1", halt_at_done, busy_at_done); end
    checks++; if (done_cyc - first_valid_cyc != 15) begin
      errors++; $display("FAIL full_rate: got %0d cycles want 15", done_cyc - first_valid_cyc); end
    repeat (3) tick();
    checks++; if (done_cnt != 1 || abort_cnt != 0) begin
      errors++; $display("FAIL full_done_cnt: got done=%0d abort=%0d want 1/0", done_cnt, abort_cnt); end
    checks++; if (busy !== 1'b0 || halt_req !== 1'b0) begin
      errors++; $display("FAIL full_after: got busy=%b halt=%b want 0/0", busy, halt_req); end
  endtask

  task automatic test_random_ready();
    halt_ack = 1'b1; out_ready = 1'b0;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      out_ready = ($urandom_range(0, 9) < 3);
      tick();
    end
    out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (done_cnt != 1 || abort_cnt != 0) begin
      errors++; $display("FAIL rand_done: got done=%0d abort=%0d want 1/0", done_cnt, abort_cnt); end
    checks++; if (bad_beats(8) != 0) begin
      errors++; $display("FAIL rand_beats: got %0d bad/%0d beats want 0/8", bad_beats(8), b_addr.size()); end
    checks++; if (stab_err != 0) begin
      errors++; $display("FAIL rand_stable: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_halt_wait();
    bit ok, v_seen, h_low;
    halt_ack = 1'b0; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    v_seen = 1'b0; h_low = 1'b0;
    repeat (50) begin
      @(negedge clock);
      if (out_valid) v_seen = 1'b1;
      if (!halt_req || !busy) h_low = 1'b1;
    end
    checks++; if (v_seen !== 1'b0) begin errors++; $display("FAIL wait_valid: got valid=1 want 0"); end
    checks++; if (h_low !== 1'b0) begin errors++; $display("FAIL wait_halt: got halt/busy low want high"); end
    tick();
    halt_ack = 1'b1;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_timeout: got no done want done"); end
    #1;
    checks++; if (bad_beats(8) != 0 || abort_cnt != 0) begin
      errors++; $display("FAIL wait_beats: got %0d bad abort=%0d want 0/0", bad_beats(8), abort_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_abort();
    bit ok;
    halt_ack = 1'b1; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_beat(3'd2, 40, ok);
    tick();
    out_ready = 1'b0;
    if (ok) wait_beat(3'd3, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach: got no beat 3 want beat 3"); end
    repeat (2) @(negedge clock);
    tick();
    halt_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if ({out_valid, done, aborted, halt_req, busy} !== 5'b01100) begin
      errors++; $display("FAIL abort_flags: got v,d,a,h,b=%b want 01100", {out_valid, done, aborted, halt_req, busy}); end
    #1;
    checks++; if (bad_beats(3) != 0) begin
      errors++; $display("FAIL abort_beats: got %0d beats (%0d bad) want 3", b_addr.size(), bad_beats(3)); end
    tick();
    checks++; if (done !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got done=%b aborted=%b want 0/0", done, aborted); end
    halt_ack = 1'b1; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(40, ok);
    #1;
    checks++; if (!ok || bad_beats(8) != 0 || abort_cnt != 0) begin
      errors++; $display("FAIL abort_redump: got ok=%b bad=%0d abort=%0d want 1/0/0", ok, bad_beats(8), abort_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_start_spam();
    halt_ack = 1'b1; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    repeat (5) begin
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat (15) tick();
    checks++; if (done_cnt != 1) begin
      errors++; $display("FAIL spam_done: got %0d want 1", done_cnt); end
    checks++; if (bad_beats(8) != 0) begin
      errors++; $display("FAIL spam_beats: got %0d beats (%0d bad) want 8", b_addr.size(), bad_beats(8)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spam_idle: got busy=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    halt_ack = 1'b1; out_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_beat(3'd3, 40, ok);
    tick();
    out_ready = 1'b0;
    if (ok) wait_beat(3'd4, 10, ok);
    checks++; if (!ok || out_data !== 16'h4444) begin
      errors++; $display("FAIL rst_reach: got ok=%b data=%h want 1/4444", ok, out_data); end
    n_rst = 1'b0;
    #1;
    checks++; if ({out_valid, halt_req, busy, done, aborted} !== 5'b0) begin
      errors++; $display("FAIL rst_async_flags: got %b want 00000", {out_valid, halt_req, busy, done, aborted}); end
    checks++; if ({rd_addr, out_addr, out_data} !== '0) begin
      errors++; $display("FAIL rst_async_bus: got rd=%0d oa=%0d od=%h want 0", rd_addr, out_addr, out_data); end
    repeat (2) tick();
    n_rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_done: got done=%0d busy=%b want 0/0", done_cnt, busy); end
    clear_mon();
    pulse_start();
    wait_done(40, ok);
    #1;
    checks++; if (!ok || bad_beats(8) != 0 || abort_cnt != 0) begin
      errors++; $display("FAIL rst_redump: got ok=%b bad=%0d abort=%0d want 1/0/0", ok, bad_beats(8), abort_cnt); end
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mem[i] = DW'(i * 'h1111);
    clear_mon();
    test_reset();
    test_full_dump();
    test_random_ready();
    test_halt_wait();
    test_abort();
    test_start_spam();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
Name: reg_dump

Overview:
Debug read-out engine on the read side of the CPU register file. On a start request it halts the pipeline with a req/ack handshake. It then walks every register-file address through a dedicated asynchronous read port and streams each (address, data) pair out over a valid/ready interface, for a host/UART debug link. It releases the halt when finished, or when the halt acknowledge is withdrawn.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, registers dumped (addresses 0..NUM_REGS-1); must be <= 2**ADDR_W

Ports:
clock  input  1  system clock, rising edge
n_rst  input  1  reset, asynchronous, active-low
start  input  1  dump request; sampled only in IDLE
halt_req  output  1  pipeline halt request to CPU control
halt_ack  input  1  CPU confirms pipeline halted and no RF writes in flight
rd_addr  output  ADDR_W  address to register-file read port
rd_data  input  DATA_W  asynchronous read data for rd_addr (same cycle)
out_valid  output  1  out_addr/out_data valid
out_ready  input  1  downstream accepts beat
out_addr  output  ADDR_W  address of current beat
out_data  output  DATA_W  register contents of current beat
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse at end of dump
aborted  output  1  qualifies done: 1 = dump cut short by halt_ack loss

Behaviour:
- Clock/reset: clock clock, reset n_rst asynchronous active-low. Reset forces state IDLE and sets the index counter, rd_addr, out_addr, out_data, out_valid, halt_req, busy, done and aborted to 0.
- All outputs are registered. rd_addr equals the index counter.
- FSM states: IDLE, HALT, READ, SEND, FIN.
- IDLE:
  - start=1 -> HALT; index:=0; halt_req:=1.
  - start is ignored in every other state. No queuing.
- HALT:
  - halt_req held at 1.
  - halt_ack=1 -> READ.
  - No timeout. The block waits indefinitely.
- READ (1 cycle):
  - out_data:=rd_data, out_addr:=index, out_valid:=1 -> SEND.
  - Data is captured at the edge leaving READ.
- SEND:
  - out_valid, out_addr and out_data are held stable until out_valid&&out_ready.
  - On handshake with index==NUM_REGS-1: out_valid:=0 -> FIN.
  - On handshake otherwise: out_valid:=0, index:=index+1 -> READ.
  - Throughput is 1 beat per 2 cycles minimum.
- FIN (1 cycle): done=1, aborted=0, halt_req:=0 -> IDLE.
- Abort:
  - Applies in READ or SEND when halt_ack=0 is sampled.
  - Any un-handshaked beat is dropped: out_valid:=0, halt_req:=0, done=1, aborted=1 -> IDLE.
  - A beat handshaked on the abort cycle counts as delivered.
  - Abort takes priority over the READ capture.
- Address 0 (zero register) is dumped like any other. Its expected value is 0.
- The index does not wrap. A dump ends after exactly NUM_REGS beats.
- busy=1 from the cycle after start is accepted through the FIN cycle inclusive.
- done and aborted are 0 outside the single terminating cycle.
- The block never writes the register file and has no effect on the CPU beyond halt_req.
- Reset mid-dump: immediate return to IDLE with halt_req=0. No done pulse.

Test Plan:
- Regs preloaded r0..r7 = 0000,1111,...,7777 hex; start pulse; halt_ack tied high; out_ready=1 -> 8 beats (addr 0..7, data 0000..7777 in order), done=1 aborted=0 once, halt_req falls with done, total 2 cycles/beat.
- Same preload; out_ready random 30% duty -> identical beat sequence, out_addr/out_data stable while valid&&!ready, no duplicates or skips.
- start with halt_ack held low 50 cycles, then raised -> no out_valid during wait, halt_req=1 throughout, then full 8-beat dump.
- halt_ack dropped while beat addr 3 pending (ready=0) -> out_valid falls, done=1 aborted=1, halt_req=0, exactly beats 0..2 delivered; new start afterwards dumps from addr 0.
- start pulsed repeatedly during a dump -> ignored, exactly one 8-beat dump and one done.
- n_rst asserted mid-SEND -> all outputs 0 asynchronously, state IDLE, no done; subsequent start works normally.
